cpu_core_mc: RTL
================

# cpu_core_mc

Parametrised multi-cycle successor to the single-cycle mini CPU core. It fetches 16-bit instructions from an external combinational instruction ROM and runs them through a FETCH/EXEC/WB state machine. It holds a 4-entry register file of DATA_W-bit registers, zero/carry flags, conditional branching, halt and run/stall control. Debug read-back lets the bench observe every register without hierarchical probing.

## Interface
- DATA_W, 8: register, ALU and immediate datapath width (4..32).
- PC_W, 4: program counter width (1..8); ROM depth is 2**PC_W.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  1 = allow the next FETCH to complete; 0 = stall in FETCH.
- instr_addr  output  PC_W  ROM address, always equals pc.
- instr_data  input  16  ROM data, combinational from instr_addr.
- dbg_sel  input  2  register index for dbg_data.
- dbg_data  output  DATA_W  combinational read of register dbg_sel.
- alu_result  output  DATA_W  registered result of the last EXEC.
- zero_flag  output  1  Z flag.
- carry_flag  output  1  C flag.
- halted  output  1  1 while in HALT state.
- illegal  output  1  sticky; set on an undefined opcode.
- retired  output  16  count of completed instructions, wraps.

## Operation
- Instruction fields: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- imm is zero-extended to DATA_W, or truncated to its low DATA_W bits if DATA_W<8.
- Jump targets are imm[PC_W-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=rd+rs, C=carry out.
  - 3 SUB: rd=rd-rs, C=borrow (1 when rd<rs unsigned).
  - 4 AND, 5 OR, 6 XOR: rd=rd op rs, C=0.
  - 7 MOV: rd=rs.
  - 8 JMP: pc=target.
  - 9 JZ: pc=target if Z=1, else pc+1.
  - A JC: same as JZ, using C.
  - F HALT.
  - B..E undefined: execute as NOP and set illegal.
- Z is written by opcodes 2..6 only (Z = result==0). C is written by 2..6 only. LDI and MOV leave both flags unchanged.
- FSM states FETCH, EXEC, WB, HALT. Reset state is FETCH.
  - FETCH: if run=1, latch instr_data into IR and go to EXEC. If run=0, stay in FETCH; no state changes.
  - EXEC: compute the result into alu_result (for LDI/MOV too: alu_result = written value). Update flags. Go to WB.
  - WB: write rd if the opcode writes a register. Update pc (jump target or pc+1, wrapping mod 2**PC_W). Increment retired. Go to FETCH; go to HALT if the opcode is HALT.
  - HALT: terminal. pc is not advanced. retired counts HALT once. Only rst_n exits.
- Registers r0..r3 are all general purpose; r0 is not hardwired.
- dbg_data reflects a WB write from the cycle after that WB edge.

## Timing
- Every instruction takes exactly 3 cycles when run is held 1: FETCH, EXEC, WB.
- N instructions retire in 3N cycles after reset release.
- instr_data is sampled at the rising edge that ends FETCH. The ROM has a full cycle from the pc update.
- Branch flags: JZ/JC use the flag value at the WB edge, which is the value left by the previous ALU instruction's EXEC.
- Reset values (asynchronous, immediate on rst_n low):
  - pc=0, IR=0, state=FETCH.
  - r0..r3=0, alu_result=0.
  - zero_flag=0, carry_flag=0, halted=0, illegal=0, retired=0.
- Reset asserted mid-instruction (EXEC or WB) aborts it: no register write, no pc change, no retired increment.
- The first FETCH completes on the first rising edge with rst_n=1 and run=1.
- run is ignored outside FETCH; an instruction already in EXEC always completes.
- retired wraps 0xFFFF→0x0000.
- pc wraps to 0 after the last ROM address.
- halted rises in the cycle after the HALT instruction's WB edge.

## Test plan
- Load/add: program LDI r0,5; LDI r1,3; ADD r0,r1; HALT.
  - r0=8, Z=0, C=0, retired=4, halted=1.
  - halted is high at cycle 12 after reset release.
- Carry/zero (DATA_W=8): LDI r0,0xFF; LDI r1,1; ADD r0,r1 → r0=0, Z=1, C=1. Then SUB r0,r1 → r0=0xFF, C=1, Z=0.
- Loop: LDI r0,3; LDI r1,1; SUB r0,r1; JZ 5; JMP 2; HALT at 5.
  - The SUB executes 3 times; final r0=0, retired=11.
- Stall: hold run=0 for 10 cycles after the first instruction. pc, registers and retired stay frozen. Timing resumes exactly 3 cycles per instruction once run returns to 1.
- Reset mid-WB of LDI r2,0x7A: r2 stays 0, pc=0, retired=0. After release, the program restarts from address 0.
- Illegal opcode 0xC at address 0, then HALT: illegal=1 and stays 1, registers unchanged, retired=2.

Source files
------------

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle mini CPU core (FETCH / EXEC / WB).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   run              allows the pending FETCH to complete
//   instr_addr       ROM address (= pc); instr_data is the combinational ROM word
//   dbg_sel/dbg_data combinational read-back of register r[dbg_sel]
//   alu_result       registered result of the last EXEC
//   zero_flag, carry_flag, halted, illegal (sticky), retired (wrapping count)
module cpu_core_mc #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [15:0]       instr_data,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              illegal,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JC   = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [4];
  logic [DATA_W-1:0] rf_d [4];
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic              ill_q, ill_d;
  logic [15:0]       ret_q, ret_d;

  // Instruction fields
  logic [3:0]        op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   target;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;

  always_comb begin
    op      = ir_q[15:12];
    rd      = ir_q[11:10];
    rs      = ir_q[9:8];
    imm_ext = DATA_W'(ir_q[7:0]);
    target  = PC_W'(ir_q[7:0]);
    a       = rf_q[rd];
    b       = rf_q[rs];
    sum     = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow (a < b unsigned).
    diff    = {1'b0, a} - {1'b0, b};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    alu_d   = alu_q;
    z_d     = z_q;
    c_d     = c_q;
    ill_d   = ill_q;
    ret_d   = ret_q;

    unique case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_LDI: alu_d = imm_ext;
          OP_MOV: alu_d = b;
          OP_ADD: begin
            alu_d = sum[DATA_W-1:0];
            z_d   = (sum[DATA_W-1:0] == '0);
            c_d   = sum[DATA_W];
          end
          OP_SUB: begin
            alu_d = diff[DATA_W-1:0];
            z_d   = (diff[DATA_W-1:0] == '0);
            c_d   = diff[DATA_W];
          end
          OP_AND: begin
            alu_d = a & b;
            z_d   = ((a & b) == '0);
            c_d   = 1'b0;
          end
          OP_OR: begin
            alu_d = a | b;
            z_d   = ((a | b) == '0);
            c_d   = 1'b0;
          end
          OP_XOR: begin
            alu_d = a ^ b;
            z_d   = ((a ^ b) == '0);
            c_d   = 1'b0;
          end
          OP_NOP, OP_JMP, OP_JZ, OP_JC, OP_HALT: ;
          default: ill_d = 1'b1;
        endcase
        state_d = S_WB;
      end

      S_WB: begin
        // alu_result already holds the value to write for opcodes 1..7.
        if (op >= OP_LDI && op <= OP_MOV) begin
          rf_d[rd] = alu_q;
        end
        case (op)
          OP_JMP:  pc_d = target;
          OP_JZ:   pc_d = z_q ? target : pc_q + PC_W'(1);
          OP_JC:   pc_d = c_q ? target : pc_q + PC_W'(1);
          default: pc_d = pc_q + PC_W'(1);
        endcase
        ret_d   = ret_q + 16'd1;
        state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      alu_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      for (int unsigned i = 0; i < 4; i++) begin
        rf_q[i] <= rf_d[i];
      end
      alu_q   <= alu_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ill_q   <= ill_d;
      ret_q   <= ret_d;
    end
  end

  assign instr_addr = pc_q;
  assign dbg_data   = rf_q[dbg_sel];
  assign alu_result = alu_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign halted     = (state_q == S_HALT);
  assign illegal    = ill_q;
  assign retired    = ret_q;

endmodule
